// File: rtl/sram_controller.sv
// Multi-cycle bridge from 32-bit MEM-stage word requests to a 16-bit asynchronous SRAM.
// Each word takes two half-word accesses (low then high) plus programmable wait cycles.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0]  WAIT_CYCLES = 4'(ACCESS_CYCLES - 3);
  localparam logic [31:0] BASE_WORD   = 32'(BASE_ADDR);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic [16:0] r_idx;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  state_t      w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;
  logic [31:0] w_offset;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;

  // Offset wraps modulo 2^32 for addresses below the base; byte lane bits are dropped.
  assign w_offset = address - BASE_WORD;

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_en || wr_en) begin
          w_state_nxt = S_LO;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LO: begin
        w_state_nxt = S_HI;
      end
      S_HI: begin
        if (WAIT_CYCLES == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = WAIT_CYCLES - 4'd1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, counter and latched request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_is_wr <= 1'b0;
      r_idx   <= 17'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_is_wr <= wr_en;
        r_idx   <= w_offset[18:2];
        r_wdata <= write_data;
      end else begin
        r_is_wr <= r_is_wr;
        r_idx   <= r_idx;
        r_wdata <= r_wdata;
      end
    end
  end

  // Capture SRAM data on the edges that end the low and high read phases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if ((r_state == S_LO) && !r_is_wr) begin
      r_rdata[15:0] <= SRAM_DQ;
    end else if ((r_state == S_HI) && !r_is_wr) begin
      r_rdata[31:16] <= SRAM_DQ;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // SRAM pin decode from the current phase and the latched operation.
  always_comb begin
    SRAM_ADDR = 18'd0;
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    w_dq_oe   = 1'b0;
    w_dq_out  = 16'd0;
    case (r_state)
      S_LO: begin
        SRAM_ADDR = {r_idx, 1'b0};
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_WE_N = ~r_is_wr;
        SRAM_OE_N = r_is_wr;
        w_dq_oe   = r_is_wr;
        w_dq_out  = r_wdata[15:0];
      end
      S_HI: begin
        SRAM_ADDR = {r_idx, 1'b1};
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_WE_N = ~r_is_wr;
        SRAM_OE_N = r_is_wr;
        w_dq_oe   = r_is_wr;
        w_dq_out  = r_wdata[31:16];
      end
      default: begin
        SRAM_ADDR = 18'd0;
        w_dq_oe   = 1'b0;
      end
    endcase
  end

  assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'hzzzz;
  assign read_data = r_rdata;
  assign ready     = ((r_state == S_IDLE) && !rd_en && !wr_en) || (r_state == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with behavioural 16-bit SRAM models
// for a default instance (6 access cycles) and a minimum-latency instance (3).
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  logic        wr3, rd3;
  logic [31:0] addr3, wdata3;
  logic [31:0] read_data3;
  logic        ready3;
  wire  [15:0] sram_dq3;
  logic [17:0] sram_addr3;
  logic        we3_n, oe3_n, ce3_n, ub3_n, lb3_n;

  logic        probe_en;
  logic        pre_we, pre_sel;
  logic [5:0]  pre_a;
  logic [15:0] pre_d;
  logic [15:0] mem  [0:63];
  logic [15:0] mem3 [0:63];

  int n_checks;
  int n_errors;

  wire [4:0] strb  = {ce_n, we_n, oe_n, ub_n, lb_n};
  wire [4:0] strb3 = {ce3_n, we3_n, oe3_n, ub3_n, lb3_n};

  sram_controller u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3), .address(addr3),
    .write_data(wdata3), .read_data(read_data3), .ready(ready3), .SRAM_DQ(sram_dq3),
    .SRAM_ADDR(sram_addr3), .SRAM_WE_N(we3_n), .SRAM_OE_N(oe3_n), .SRAM_CE_N(ce3_n),
    .SRAM_UB_N(ub3_n), .SRAM_LB_N(lb3_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: drive on read, store on write; bench can also float a probe pattern.
  assign sram_dq  = (!ce_n && !oe_n && we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
  assign sram_dq  = probe_en ? 16'h5A5A : 16'hzzzz;
  assign sram_dq3 = (!ce3_n && !oe3_n && we3_n) ? mem3[sram_addr3[5:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (pre_we && !pre_sel) mem[pre_a] <= pre_d;
    else if (!ce_n && !we_n) mem[sram_addr[5:0]] <= sram_dq;
  end

  always @(negedge clk) begin
    if (pre_we && pre_sel) mem3[pre_a] <= pre_d;
    else if (!ce3_n && !we3_n) mem3[sram_addr3[5:0]] <= sram_dq3;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic sel, input logic [5:0] a, input logic [15:0] d);
    pre_sel = sel; pre_a = a; pre_d = d; pre_we = 1'b1;
    @(negedge clk); #1;
    pre_we = 1'b0;
  endtask

  // One transaction on the default instance; starts and ends just after a rising edge.
  task automatic txn(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                     input logic hold, input logic [17:0] exp_a, input logic chk_rd,
                     input logic [31:0] exp_rd, input string tag);
    wr_en = wr; rd_en = rd; address = a; write_data = wd;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("%s ready c%0d", tag, c), {31'd0, ready}, (c == 6) ? 32'd1 : 32'd0);
      if (c == 1 || c == 2) begin
        check($sformatf("%s strobes c%0d", tag, c), {27'd0, strb}, wr ? 32'h04 : 32'h08);
        check($sformatf("%s addr c%0d", tag, c), {14'd0, sram_addr},
              {14'd0, exp_a + 18'(c - 1)});
        if (wr)
          check($sformatf("%s dq c%0d", tag, c), {16'd0, sram_dq},
                (c == 1) ? {16'd0, wd[15:0]} : {16'd0, wd[31:16]});
      end else if (c == 3) begin
        check($sformatf("%s wait strobes", tag), {27'd0, strb}, 32'h1F);
        check($sformatf("%s wait addr", tag), {14'd0, sram_addr}, 32'd0);
      end else if (c == 6 && chk_rd) begin
        check($sformatf("%s read_data", tag), read_data, exp_rd);
      end
      @(posedge clk); #1;
      if (!hold && c == 0) begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    wr3 = 1'b0; rd3 = 1'b0; addr3 = 32'd0; wdata3 = 32'd0;
    probe_en = 1'b0; pre_we = 1'b0; pre_sel = 1'b0; pre_a = 6'd0; pre_d = 16'd0;

    // 1: reset state
    repeat (2) @(posedge clk);
    preload(1'b0, 6'd2, 16'h5566);
    preload(1'b0, 6'd3, 16'h7788);
    preload(1'b1, 6'd0, 16'h1111);
    preload(1'b1, 6'd1, 16'h2222);
    probe_en = 1'b1;
    @(negedge clk);
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst read_data", read_data, 32'd0);
    check("rst strobes", {27'd0, strb}, 32'h1F);
    check("rst addr", {14'd0, sram_addr}, 32'd0);
    check("rst dq float", {16'd0, sram_dq}, 32'h5A5A);
    probe_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // 2: write DEADBEEF at word 0
    txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 18'd0, 1'b0, 32'd0, "wr1024");
    check("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    check("rdata held on write", read_data, 32'd0);

    // 3: reads
    txn(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, 18'd0, 1'b1, 32'hDEADBEEF, "rd1024");
    txn(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 18'd2, 1'b1, 32'h77885566, "rd1028");

    // 4: back-to-back write held through DONE, then read
    txn(1'b1, 1'b0, 32'd1032, 32'h12345678, 1'b1, 18'd4, 1'b0, 32'd0, "b2b wr");
    txn(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 18'd4, 1'b1, 32'h12345678, "b2b rd");
    check("mem4", {16'd0, mem[4]}, 32'h00005678);
    check("mem5", {16'd0, mem[5]}, 32'h00001234);

    // 5: minimum latency instance
    rd3 = 1'b1; addr3 = 32'd1024;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("ac3 ready c%0d", c), {31'd0, ready3}, (c == 3) ? 32'd1 : 32'd0);
      if (c == 2) begin
        check("ac3 hi strobes", {27'd0, strb3}, 32'h08);
        check("ac3 hi addr", {14'd0, sram_addr3}, 32'd1);
      end else if (c == 3) begin
        check("ac3 done strobes", {27'd0, strb3}, 32'h1F);
        check("ac3 read_data", read_data3, 32'h22221111);
      end
      @(posedge clk); #1;
      if (c == 0) rd3 = 1'b0;
    end

    // 6: reset during HI of a write, then simultaneous rd/wr
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #1;
    check("abort in HI", {14'd0, sram_addr}, 32'd9);
    rst = 1'b0;
    probe_en = 1'b1;
    #1;
    check("abort strobes", {27'd0, strb}, 32'h1F);
    check("abort addr", {14'd0, sram_addr}, 32'd0);
    check("abort read_data", read_data, 32'd0);
    check("abort ready", {31'd0, ready}, 32'd1);
    check("abort dq float", {16'd0, sram_dq}, 32'h5A5A);
    probe_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("partial mem8", {16'd0, mem[8]}, 32'h0000F00D);
    txn(1'b1, 1'b1, 32'd1040, 32'h0BADCAFE, 1'b0, 18'd8, 1'b0, 32'd0, "rdwr1040");
    check("mem8", {16'd0, mem[8]}, 32'h0000CAFE);
    check("mem9", {16'd0, mem[9]}, 32'h00000BAD);
    check("rdata after write", read_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
